// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive side (and by uart_data_tx).
//
// Contents:
//   CLK_FREQ   - system clock frequency in Hz (50 MHz).
//   baud_sel_e - encoding of the 3-bit baud_set input.
//   BPS_TABLE  - clock cycles per bit for each baud_set value.
//   rx_state_e - states of the byte receiver FSM.
package uart_pkg;

    localparam int unsigned CLK_FREQ = 50_000_000;

    // Wide enough for the slowest divisor (5208 at 9600 baud).
    localparam int BPS_W = 13;

    typedef enum logic [2:0] {
        BAUD_9600   = 3'd0,
        BAUD_19200  = 3'd1,
        BAUD_38400  = 3'd2,
        BAUD_57600  = 3'd3,
        BAUD_115200 = 3'd4,
        BAUD_230400 = 3'd5,
        BAUD_460800 = 3'd6,
        BAUD_921600 = 3'd7
    } baud_sel_e;

    // Divisor rounded to the nearest whole clock cycle.
    function automatic int unsigned baud_div(input int unsigned baud);
        return (CLK_FREQ + baud / 2) / baud;
    endfunction

    // Indexed directly by baud_set; resolves to 5208, 2604, 1302, 868,
    // 434, 217, 109, 54 for a 50 MHz clock.
    localparam logic [BPS_W-1:0] BPS_TABLE [8] = '{
        BPS_W'(baud_div(9600)),
        BPS_W'(baud_div(19200)),
        BPS_W'(baud_div(38400)),
        BPS_W'(baud_div(57600)),
        BPS_W'(baud_div(115200)),
        BPS_W'(baud_div(230400)),
        BPS_W'(baud_div(460800)),
        BPS_W'(baud_div(921600))
    };

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_byte_rx.sv
// Single-byte 8N1 receiver: input synchroniser, baud counter and byte FSM.
//
// Ports:
//   clk, reset    - system clock, synchronous active-high reset.
//   uart_rx_i     - asynchronous serial line, idles high.
//   baud_set_i    - baud select, latched only while the FSM is idle.
//   rx_byte_o     - received byte (valid while byte_valid_o is high).
//   byte_valid_o  - one-cycle pulse: byte received with a good stop bit.
//   frame_err_o   - one-cycle pulse: stop bit sampled low, byte dropped.
//   start_ok_o    - one-cycle pulse: start bit confirmed at mid-bit.
//   bps_o         - bit period currently in use, in clock cycles.
//   state_o       - byte FSM state (RX_IDLE means not busy).
module uart_byte_rx
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             uart_rx_i,
    input  logic [2:0]       baud_set_i,
    output logic [7:0]       rx_byte_o,
    output logic             byte_valid_o,
    output logic             frame_err_o,
    output logic             start_ok_o,
    output logic [BPS_W-1:0] bps_o,
    output rx_state_e        state_o
);

    logic             sync1_q, sync2_q, hist_q;
    logic [1:0]       prime_q;
    logic             armed_q;
    rx_state_e        state_q, state_d;
    logic [BPS_W-1:0] cnt_q, cnt_d;
    logic [BPS_W-1:0] bps_q, bps_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             start_ok_q, start_ok_d;

    logic             fall;
    logic [BPS_W-1:0] half_m1, full_m1;

    // The synchroniser flops reset high, so right after reset sync2_q
    // does not yet reflect the pin. prime_q marks when it does; only then
    // can a high line arm start detection. A line held low through reset
    // therefore never counts as a start edge.
    assign fall    = armed_q & hist_q & ~sync2_q;
    assign half_m1 = (bps_q >> 1) - BPS_W'(1);
    assign full_m1 = bps_q - BPS_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            hist_q       <= 1'b1;
            prime_q      <= 2'b00;
            armed_q      <= 1'b0;
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bps_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            start_ok_q   <= 1'b0;
        end else begin
            sync1_q      <= uart_rx_i;
            sync2_q      <= sync1_q;
            hist_q       <= sync2_q;
            prime_q      <= {prime_q[0], 1'b1};
            armed_q      <= armed_q | (prime_q[1] & sync2_q);
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bps_q        <= bps_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            start_ok_q   <= start_ok_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + BPS_W'(1);
        bps_d        = bps_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        start_ok_d   = 1'b0;

        case (state_q)
            RX_IDLE: begin
                // Tracking baud_set only here means a mid-byte change
                // takes effect from the next start bit.
                bps_d = BPS_TABLE[baud_set_i];
                cnt_d = '0;
                if (fall) begin
                    state_d = RX_START;
                    bit_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == half_m1) begin
                    cnt_d = '0;
                    if (!sync2_q) begin
                        state_d    = RX_DATA;
                        start_ok_d = 1'b1;
                    end else begin
                        // Line back high at mid-start: a glitch, not a frame.
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (cnt_q == full_m1) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = sync2_q;
                    bit_d          = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                // Returning to idle at mid-stop re-arms start detection half
                // a bit early, which absorbs a few percent of baud error.
                if (cnt_q == full_m1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (sync2_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte_o    = shift_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;
    assign start_ok_o   = start_ok_q;
    assign bps_o        = bps_q;
    assign state_o      = state_q;

endmodule

// File: rtl/uart_data_rx.sv
// Multi-byte UART receiver: packs DATA_WIDTH/8 consecutive 8N1 bytes into
// one word and presents it with a one-cycle rx_done pulse.
//
// Parameters:
//   DATA_WIDTH   - word width in bits, a multiple of 8.
//   MSB_FIRST    - 0: first byte lands in data[7:0];
//                  1: first byte lands in data[DATA_WIDTH-1 -: 8].
//   TIMEOUT_BITS - idle bit-times allowed between bytes of one word.
//
// Ports:
//   clk, reset - 50 MHz clock, synchronous active-high reset.
//   uart_rx    - serial input, idles high.
//   baud_set   - baud select (0=9600 .. 7=921600).
//   data       - last complete word, held until the next one completes.
//   rx_done    - one-cycle pulse when data updates.
//   frame_err  - one-cycle pulse on a bad stop bit.
//   uart_state - high while a word is being received.
module uart_data_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 256,
    parameter int MSB_FIRST    = 0,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uart_rx,
    input  logic [2:0]            baud_set,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  rx_done,
    output logic                  frame_err,
    output logic                  uart_state
);

    localparam int N     = DATA_WIDTH / 8;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    logic [7:0]       rx_byte;
    logic             byte_valid;
    logic             byte_ferr;
    logic             start_ok;
    logic [BPS_W-1:0] bps;
    rx_state_e        byte_state;
    logic             byte_busy;

    uart_byte_rx u_byte_rx (
        .clk          (clk),
        .reset        (reset),
        .uart_rx_i    (uart_rx),
        .baud_set_i   (baud_set),
        .rx_byte_o    (rx_byte),
        .byte_valid_o (byte_valid),
        .frame_err_o  (byte_ferr),
        .start_ok_o   (start_ok),
        .bps_o        (bps),
        .state_o      (byte_state)
    );

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rx_done_q, rx_done_d;
    logic                  active_q, active_d;
    logic                  pending_q, pending_d;
    logic [31:0]           tmo_q, tmo_d;

    logic [CNT_W-1:0]      slot;
    logic [31:0]           tmo_limit;
    logic                  tmo_hit;

    assign byte_busy = (byte_state != RX_IDLE);
    assign slot      = (MSB_FIRST != 0) ? (LAST_IDX - cnt_q) : cnt_q;
    assign tmo_limit = 32'(TIMEOUT_BITS) * 32'(bps);
    // The gap timer only runs between bytes of a partial word and pauses
    // while a byte is being received; a start glitch resumes it.
    assign tmo_hit   = (cnt_q != '0) && !byte_busy && (tmo_q >= tmo_limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            shadow_q  <= '0;
            data_q    <= '0;
            rx_done_q <= 1'b0;
            active_q  <= 1'b0;
            pending_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            data_q    <= data_d;
            rx_done_q <= rx_done_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        data_d    = data_q;
        rx_done_d = 1'b0;
        active_d  = active_q;
        pending_d = 1'b0;
        tmo_d     = tmo_q;

        // Final byte landed in the shadow last cycle: publish the word.
        if (pending_q) begin
            data_d    = shadow_q;
            rx_done_d = 1'b1;
            active_d  = 1'b0;
        end

        if (byte_valid) begin
            shadow_d[{slot, 3'b000} +: 8] = rx_byte;
            tmo_d = '0;
            if (cnt_q == LAST_IDX) begin
                cnt_d     = '0;
                pending_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (byte_ferr || tmo_hit) begin
            // Abort: drop the partial word, leave data untouched.
            cnt_d    = '0;
            active_d = 1'b0;
            tmo_d    = '0;
        end else if (cnt_q != '0 && !byte_busy) begin
            tmo_d = tmo_q + 32'd1;
        end

        if (start_ok && cnt_q == '0) begin
            active_d = 1'b1;
        end
    end

    assign data       = data_q;
    assign rx_done    = rx_done_q;
    assign frame_err  = byte_ferr;
    assign uart_state = active_q;

endmodule

// File: doc/uart_data_rx.md
Name: uart_data_rx

Overview:
Multi-byte UART receiver, the receive-side counterpart of uart_data_tx. It deserialises 8N1 frames from a single serial line and packs DATA_WIDTH/8 consecutive bytes into one word. It presents that word with a one-cycle done pulse. It sits behind the board RX pin, or directly on a uart_data_tx line in loopback benches, and uses the same baud_set encoding and byte ordering as the transmitter.

Parameters:
DATA_WIDTH, 256, word width in bits; multiple of 8, >= 8.
MSB_FIRST, 0, 0: first received byte goes to data[7:0]; 1: first received byte goes to data[DATA_WIDTH-1 -: 8].
TIMEOUT_BITS, 20, idle bit-times allowed between bytes of one word before the partial word is dropped.

Ports:
clk  input  1  system clock, 50 MHz.
reset  input  1  synchronous, active-high reset.
uart_rx  input  1  asynchronous serial input; idles high.
baud_set  input  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5=230400, 6=460800, 7=921600.
data  output  DATA_WIDTH  last complete word; holds its value until the next word completes.
rx_done  output  1  one-cycle pulse when data updates.
frame_err  output  1  one-cycle pulse on a bad stop bit.
uart_state  output  1  high while a word is in progress.

Behaviour:
- Reset values: data=0, rx_done=0, frame_err=0, uart_state=0, byte count=0, synchroniser flops=1, byte FSM=IDLE.
- Input conditioning: uart_rx passes through a 2-flop synchroniser, then one more history flop for edge detection.
- Bit period BPS_DR is taken from a table (50 MHz clock): 5208, 2604, 1302, 868, 434, 217, 109, 54. baud_set is latched only in IDLE; a change mid-byte applies from the next byte.
- Byte FSM states:
  - IDLE: on a synchronised falling edge, clear the bit counter and go to START.
  - START: at BPS_DR/2 cycles, sample the line. If 0, go to DATA. If 1, treat it as a glitch and return to IDLE with no error.
  - DATA: every BPS_DR cycles sample one bit into rx_byte[i], i=0..7 (LSB first on the line). After bit 7, go to STOP.
  - STOP: after BPS_DR cycles, sample the line. If 1, pulse byte_valid; if 0, pulse frame_err and discard the byte. Return to IDLE in the same cycle. Next-start detection is therefore armed at mid-stop-bit, which tolerates a +/-4% baud mismatch.
- Word assembly:
  - On byte_valid, write the byte into a shadow register at slot idx = byte count (MSB_FIRST=0) or N-1-byte count (MSB_FIRST=1), where N=DATA_WIDTH/8.
  - When byte count reaches N-1: on the next cycle, copy shadow to data, assert rx_done for one cycle and clear byte count.
  - Latency: rx_done asserts 2 clk after the final stop-bit sample.
- uart_state: set on the start-bit detect of byte 0 (only a validated start counts). Cleared on the same cycle as rx_done or on any abort.
- Abort conditions (byte count cleared, partial word discarded, data unchanged, no rx_done):
  - frame_err.
  - Byte count != 0 and no new start edge within TIMEOUT_BITS*BPS_DR cycles of the last stop sample.
- Line held low (break): the stop sample is 0, so frame_err fires, then IDLE waits for a falling edge. No repeated errors occur while the line stays low.
- N=1: every valid byte produces rx_done.
- Reset asserted mid-frame returns all state to reset values on the next edge. A frame in progress is lost. A start edge is only recognised after the line has been seen high following reset.

Decomposition:
- Shared package uart_pkg:
  - Baud divisor table and the baud_set encoding, shared with uart_data_tx.
  - Byte FSM state typedef.
  - CLK_FREQ constant.
- Sub-module uart_byte_rx: synchroniser, baud counter and byte FSM. Outputs rx_byte, byte_valid, frame_err and a busy flag.
- uart_data_rx contains the word assembler, timeout counter and output registers.

Test Plan:
- Single word, DATA_WIDTH=32, MSB_FIRST=0, baud_set=4. Drive bytes 0x87,0x09,0xBA,0xDC -> one rx_done pulse, data=32'hDCBA0987; uart_state high from the first start edge until rx_done.
- Same bytes with MSB_FIRST=1 -> data=32'h8709BADC. Then a 256-bit loopback against uart_data_tx, data=256'h890a...0987, at baud_set=4 and 0 -> data matches the transmitted value exactly, one rx_done each.
- Frame error: byte 2 sent with stop bit=0 -> frame_err pulse, no rx_done, data unchanged. A subsequent clean 4-byte word is received correctly.
- Timeout: 2 bytes, then idle for 25 bit-times (TIMEOUT_BITS=20), then 4 bytes 0x11,0x22,0x33,0x44 -> data=32'h44332211, no stale bytes.
- Glitch: a 100 ns low pulse on idle uart_rx -> no state change, no frame_err. Baud mismatch: transmitter running 3% fast at baud_set=4 -> word still received correctly.
- Reset: assert reset mid-byte 3 for 1 cycle -> all outputs 0 next cycle. A new full word after that is received correctly.
